// File: rtl/uid_alloc_arbiter.sv
// Shared UID allocator: round-robin grant of one free slot per cycle, original-ID tag map, free path.
// Optional per-requester grant and full-cycle statistics under `UID_ALLOC_STATS_EN.
module uid_alloc_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ID_WIDTH  = 32,
  parameter int NUM_UIDS  = 16,
  parameter int CNT_WIDTH = $clog2(NUM_UIDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          alloc_req,
  input  logic [NUM_REQ*ID_WIDTH-1:0] alloc_in_id,
  output logic [NUM_REQ-1:0]          alloc_gnt,
  output logic [ID_WIDTH-1:0]         unique_id,
  output logic                        tag_map_full,
  input  logic                        free_valid,
  input  logic [ID_WIDTH-1:0]         free_uid,
  output logic [ID_WIDTH-1:0]         free_orig_id,
  output logic [CNT_WIDTH-1:0]        used_count,
  output logic                        err_free
`ifdef UID_ALLOC_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]       grant_cnt,
  output logic [31:0]                 full_cycles
`endif
);

  localparam int SLOT_W = $clog2(NUM_UIDS);
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_UIDS-1:0] valid_map;
  logic [ID_WIDTH-1:0] orig_tbl [NUM_UIDS];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    cand;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [SLOT_W-1:0]   sel_slot;
  logic [SLOT_W-1:0]   free_slot;
  logic                free_hit;
  logic                has_free;
  logic                unused_free_uid_hi;

  assign free_slot          = free_uid[SLOT_W-1:0];
  assign unused_free_uid_hi = ^free_uid[ID_WIDTH-1:SLOT_W];
  assign free_hit           = free_valid && valid_map[free_slot];
  assign has_free           = ~&valid_map;
  assign tag_map_full       = (used_count == CNT_WIDTH'(NUM_UIDS));
  assign free_orig_id       = orig_tbl[free_slot];

  // Lowest free slot is taken from the registered bitmap, so a slot freed this cycle is never reused
  always_comb begin
    sel_slot = '0;
    for (int s = NUM_UIDS - 1; s >= 0; s--) begin
      if (!valid_map[s]) sel_slot = SLOT_W'(s);
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && alloc_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
        gnt_id  = alloc_in_id[int'(cand)*ID_WIDTH +: ID_WIDTH];
      end
    end
    if (!rst || !has_free) gnt_any = 1'b0;
    alloc_gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
    unique_id = gnt_any ? ID_WIDTH'(sel_slot) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_map  <= '0;
      rr_ptr     <= '0;
      used_count <= '0;
      err_free   <= 1'b0;
    end else begin
      err_free   <= free_valid && !valid_map[free_slot];
      used_count <= used_count + CNT_WIDTH'(gnt_any) - CNT_WIDTH'(free_hit);
      if (free_hit) valid_map[free_slot] <= 1'b0;
      if (gnt_any) begin
        valid_map[sel_slot] <= 1'b1;
        rr_ptr              <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
      end
    end
  end

  // Tag table is data only; contents after reset are irrelevant until a slot is granted
  always_ff @(posedge clk) begin
    if (gnt_any) orig_tbl[sel_slot] <= gnt_id;
  end

`ifdef UID_ALLOC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt   <= '0;
      full_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (alloc_gnt[i] && grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)
          grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
      end
      if (tag_map_full && full_cycles != 32'hFFFF_FFFF)
        full_cycles <= full_cycles + 32'd1;
    end
  end
`endif

endmodule
